kmeans_centroid_update_k2_d4: RTL and testbench
===============================================

// Module: kmeans_centroid_update_k2_d4
// PURPOSE
//  Downstream consumer of the k=2, d=4 distance/argmin pipeline. Accumulates each classified
//  point into per-centroid sums and counts. At end of pass, divides sums by counts to produce
//  new centroids, which drive the pipeline's centroid inputs. One sequential divider, shared.
// PARAMETERS
//  input_data_width  16  bit width of one unsigned coordinate (matches upstream pipeline)
//  count_width       16  per-centroid point counter width; sum width SW = input_data_width+count_width
// PORTS
//  clk                 in   1    clock, all state on rising edge
//  rst                 in   1    synchronous reset, active-high
//  in_valid            in   1    point present on in_data*/in_idx (upstream valid delayed by its latency 5)
//  in_last             in   1    qualifies in_valid: final point of current pass
//  in_data0..3         in   W    point coordinates (upstream output_data0..3)
//  in_idx              in   1    winning centroid (upstream selected_centroid)
//  load_en             in   1    write initial centroid; honoured only in ACCUM
//  load_idx            in   1    centroid index for load
//  load_d0..3          in   W    initial coordinates for load
//  centroid0_d0..d3    out  W    current centroid 0 (to upstream centroid0_d*)
//  centroid1_d0..d3    out  W    current centroid 1
//  count0, count1      out  count_width  points counted in the pass being accumulated
//  busy                out  1    high in DIVIDE state
//  update_done         out  1    one-cycle pulse when all 8 new coordinates are committed
//  err_drop            out  1    sticky: in_valid or load_en arrived while busy
//  err_ovf             out  1    sticky: a count saturated
// BEHAVIOUR
//  Reset: all centroid outputs, sums, counts, busy, update_done, err_drop, err_ovf = 0;
//   state ACCUM.
//  States: ACCUM -> DIVIDE on accepted in_last; DIVIDE -> ACCUM after 8th quotient committed.
//  ACCUM, in_valid=1:
//   - sum[in_idx][d] += in_data_d (SW bits, unsigned).
//   - count[in_idx] += 1.
//   - The point is accepted in the same cycle.
//   - If the count equals all-ones, it holds (saturates), err_ovf<=1, and the sum is not updated.
//  in_last accepted: point is accumulated first, then state=DIVIDE on the next edge.
//  in_last without in_valid is ignored.
//  DIVIDE:
//   - Order is k0d0,k0d1,k0d2,k0d3,k1d0..k1d3.
//   - Each quotient takes exactly SW+1 cycles: 1 start cycle plus SW restoring iterations.
//   - Quotient = floor(sum/count), truncated to W bits; it is written to that centroid
//     coordinate on completion.
//   - count==0 for a centroid: its 4 coordinates keep their old values. The slot still
//     consumes SW+1 cycles, so latency is constant.
//  Latency: if in_last is sampled at edge T, update_done is high in the cycle after edge
//   T+1+8*(SW+1). On that same edge, sums/counts clear to 0 and state=ACCUM.
//  Centroid outputs change only at quotient commit or on load, never mid-iteration.
//  While busy:
//   - in_valid and load_en are dropped and err_drop<=1.
//   - count0/count1 keep their end-of-pass values until cleared.
//  err_drop and err_ovf clear only on rst or on an accepted load_en.
//  load_en together with in_valid in ACCUM: both act; the load changes only the centroid regs.
//  rst mid-DIVIDE: abort; every register returns to its reset value on the next edge.
// STRUCTURE
//  Shared package kmeans_pkg:
//   - K=2, D=4, and SW derivation;
//   - state enum {ACCUM, DIVIDE};
//   - slot index width clog2(K*D).
//  Sub-module kmeans_divider_seq (SW-bit dividend, count_width divisor, start/done,
//   W-bit quotient). The top holds the accumulators, the FSM, slot counter and commit logic.
// TESTING
//  1. Load c0=(0,0,0,0), c1=(100,100,100,100); feed points (2,4,6,8)->idx0 and (10,10,10,10)->idx0
//     last -> c0=(6,7,8,9), c1 unchanged, count0=2, count1=0, update_done once.
//  2. Non-integer mean: (1,1,1,1) and (2,2,2,2) to idx1 -> c1=(1,1,1,1) (floor).
//  3. Latency: W=16, count_width=16, SW=32. Check update_done exactly 1+8*33=265 cycles after
//     the in_last edge; busy is high throughout.
//  4. in_valid and load_en pulsed during DIVIDE -> err_drop=1, sums/centroids unaffected,
//     result matches scenario 1.
//  5. count_width=2: feed 4 points to idx0 -> count0=3, err_ovf=1, 4th point excluded from sum.
//  6. Assert rst 10 cycles into DIVIDE -> next cycle all outputs 0, busy=0, no update_done.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared constants and types for the k=2, d=4 centroid update block.
package kmeans_pkg;
    localparam int K      = 2;
    localparam int D      = 4;
    localparam int NSLOT  = K * D;
    localparam int SLOT_W = $clog2(NSLOT);

    typedef enum logic {
        ACCUM  = 1'b0,
        DIVIDE = 1'b1
    } state_t;

    // Sum width is coordinate width plus count width, so a full count of max values cannot wrap.
    function automatic int sum_width(input int data_w, input int count_w);
        return data_w + count_w;
    endfunction
endpackage

// File: rtl/kmeans_divider_seq.sv
// Restoring sequential divider: one load cycle, then DW shift/subtract iterations.
module kmeans_divider_seq #(
    parameter int DW = 32,
    parameter int VW = 16,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          done_o,
    output logic [QW-1:0] quotient_o
);
    localparam int IT_W = $clog2(DW + 1);

    logic [VW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [VW-1:0]   div_q, div_d;
    logic [IT_W-1:0] iter_q, iter_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic [VW:0]     rem_sh, rem_sub;
    logic            ge;

    assign rem_sh  = {rem_q, quo_q[DW-1]};
    assign ge      = (rem_sh >= {1'b0, div_q});
    assign rem_sub = rem_sh - {1'b0, div_q};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        iter_d = iter_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            div_d  = divisor_i;
            iter_d = IT_W'(DW);
            run_d  = 1'b1;
        end else if (run_q) begin
            // The remainder stays below the divisor, so VW bits always hold it.
            rem_d  = ge ? rem_sub[VW-1:0] : rem_sh[VW-1:0];
            quo_d  = {quo_q[DW-2:0], ge};
            iter_d = iter_q - IT_W'(1);
            if (iter_q == IT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q[QW-1:0];
endmodule

// File: rtl/kmeans_centroid_update_k2_d4.sv
// Accumulates classified points per centroid and, at end of pass, divides sums by counts
// with one shared sequential divider to produce the next centroids.
module kmeans_centroid_update_k2_d4
    import kmeans_pkg::*;
#(
    parameter int input_data_width = 16,
    parameter int count_width      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [input_data_width-1:0] in_data0,
    input  logic [input_data_width-1:0] in_data1,
    input  logic [input_data_width-1:0] in_data2,
    input  logic [input_data_width-1:0] in_data3,
    input  logic                        in_idx,
    input  logic                        load_en,
    input  logic                        load_idx,
    input  logic [input_data_width-1:0] load_d0,
    input  logic [input_data_width-1:0] load_d1,
    input  logic [input_data_width-1:0] load_d2,
    input  logic [input_data_width-1:0] load_d3,
    output logic [input_data_width-1:0] centroid0_d0,
    output logic [input_data_width-1:0] centroid0_d1,
    output logic [input_data_width-1:0] centroid0_d2,
    output logic [input_data_width-1:0] centroid0_d3,
    output logic [input_data_width-1:0] centroid1_d0,
    output logic [input_data_width-1:0] centroid1_d1,
    output logic [input_data_width-1:0] centroid1_d2,
    output logic [input_data_width-1:0] centroid1_d3,
    output logic [count_width-1:0]      count0,
    output logic [count_width-1:0]      count1,
    output logic                        busy,
    output logic                        update_done,
    output logic                        err_drop,
    output logic                        err_ovf,
    output logic                        dbg_state
);
    localparam int W  = input_data_width;
    localparam int CW = count_width;
    localparam int SW = sum_width(W, CW);

    state_t              state_q, state_d;
    logic [SW-1:0]       sum_q  [K][D];
    logic [SW-1:0]       sum_d  [K][D];
    logic [CW-1:0]       cnt_q  [K];
    logic [CW-1:0]       cnt_d  [K];
    logic [W-1:0]        cent_q [K][D];
    logic [W-1:0]        cent_d [K][D];
    logic [SLOT_W-1:0]   slot_q, slot_d, div_slot;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic [W-1:0]        in_data [D];
    logic [W-1:0]        load_d  [D];
    logic                div_start, div_done;
    logic [W-1:0]        div_quot;

    assign in_data = '{in_data0, in_data1, in_data2, in_data3};
    assign load_d  = '{load_d0, load_d1, load_d2, load_d3};

    // First slot starts one cycle after entry so the last point's sum is already registered.
    assign div_slot  = pend_q ? '0 : slot_q + SLOT_W'(1);
    assign div_start = pend_q | (div_done & (slot_q != SLOT_W'(NSLOT - 1)));

    kmeans_divider_seq #(.DW(SW), .VW(CW), .QW(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (sum_q[div_slot[SLOT_W-1]][div_slot[1:0]]),
        .divisor_i  (cnt_q[div_slot[SLOT_W-1]]),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cent_d  = cent_q;
        slot_d  = slot_q;
        pend_d  = 1'b0;
        done_d  = 1'b0;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (load_en) begin
                    for (int j = 0; j < D; j++) cent_d[load_idx][j] = load_d[j];
                    drop_d = 1'b0;
                    ovf_d  = 1'b0;
                end
                if (in_valid) begin
                    if (cnt_q[in_idx] == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d[in_idx] = cnt_q[in_idx] + CW'(1);
                        for (int j = 0; j < D; j++)
                            sum_d[in_idx][j] = sum_q[in_idx][j] + SW'(in_data[j]);
                    end
                    if (in_last) begin
                        state_d = DIVIDE;
                        pend_d  = 1'b1;
                        slot_d  = '0;
                    end
                end
            end
            DIVIDE: begin
                if (in_valid || load_en) drop_d = 1'b1;
                if (div_done) begin
                    // An empty centroid keeps its old coordinates.
                    if (cnt_q[slot_q[SLOT_W-1]] != '0)
                        cent_d[slot_q[SLOT_W-1]][slot_q[1:0]] = div_quot;
                    if (slot_q == SLOT_W'(NSLOT - 1)) begin
                        state_d = ACCUM;
                        done_d  = 1'b1;
                        slot_d  = '0;
                        sum_d   = '{default: '0};
                        cnt_d   = '{default: '0};
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            sum_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
            cent_q  <= '{default: '0};
            slot_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cent_q  <= cent_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign centroid0_d0 = cent_q[0][0];
    assign centroid0_d1 = cent_q[0][1];
    assign centroid0_d2 = cent_q[0][2];
    assign centroid0_d3 = cent_q[0][3];
    assign centroid1_d0 = cent_q[1][0];
    assign centroid1_d1 = cent_q[1][1];
    assign centroid1_d2 = cent_q[1][2];
    assign centroid1_d3 = cent_q[1][3];
    assign count0       = cnt_q[0];
    assign count1       = cnt_q[1];
    assign busy         = (state_q == DIVIDE);
    assign update_done  = done_q;
    assign err_drop     = drop_q;
    assign err_ovf      = ovf_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_kmeans_centroid_update_k2_d4.sv
// Directed bench: a reference model pushes expected centroids when a pass ends; they are
// popped and compared when update_done appears.
module tb_kmeans_centroid_update_k2_d4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_valid_b, in_last, in_last_b, in_idx;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic         load_en, load_idx;
    logic [W-1:0] load_d0, load_d1, load_d2, load_d3;

    logic [W-1:0] c0_0, c0_1, c0_2, c0_3, c1_0, c1_1, c1_2, c1_3;
    logic [W-1:0] cb0_0, cb0_1, cb0_2, cb0_3, cb1_0, cb1_1, cb1_2, cb1_3;
    logic [15:0]  count0, count1;
    logic [1:0]   count0_b, count1_b;
    logic         busy, update_done, err_drop, err_ovf, dbg_state;
    logic         busy_b, update_done_b, err_drop_b, err_ovf_b, dbg_state_b;

    kmeans_centroid_update_k2_d4 u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_idx(in_idx), .load_en(load_en), .load_idx(load_idx),
        .load_d0(load_d0), .load_d1(load_d1), .load_d2(load_d2), .load_d3(load_d3),
        .centroid0_d0(c0_0), .centroid0_d1(c0_1), .centroid0_d2(c0_2), .centroid0_d3(c0_3),
        .centroid1_d0(c1_0), .centroid1_d1(c1_1), .centroid1_d2(c1_2), .centroid1_d3(c1_3),
        .count0(count0), .count1(count1), .busy(busy), .update_done(update_done),
        .err_drop(err_drop), .err_ovf(err_ovf), .dbg_state(dbg_state)
    );

    kmeans_centroid_update_k2_d4 #(.count_width(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_last(in_last_b),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_idx(in_idx), .load_en(1'b0), .load_idx(1'b0),
        .load_d0(load_d0), .load_d1(load_d1), .load_d2(load_d2), .load_d3(load_d3),
        .centroid0_d0(cb0_0), .centroid0_d1(cb0_1), .centroid0_d2(cb0_2), .centroid0_d3(cb0_3),
        .centroid1_d0(cb1_0), .centroid1_d1(cb1_1), .centroid1_d2(cb1_2), .centroid1_d3(cb1_3),
        .count0(count0_b), .count1(count1_b), .busy(busy_b), .update_done(update_done_b),
        .err_drop(err_drop_b), .err_ovf(err_ovf_b), .dbg_state(dbg_state_b)
    );

    int              n_pass  = 0;
    int              n_total = 0;
    logic [127:0]    exp_q[$];
    longint unsigned m_sum [2][4];
    longint unsigned m_cnt [2];
    logic [W-1:0]    m_cent[2][4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] obs_a();
        return {c1_3, c1_2, c1_1, c1_0, c0_3, c0_2, c0_1, c0_0};
    endfunction

    function automatic logic [127:0] obs_b();
        return {cb1_3, cb1_2, cb1_1, cb1_0, cb0_3, cb0_2, cb0_1, cb0_0};
    endfunction

    function automatic logic [127:0] model_pack();
        return {m_cent[1][3], m_cent[1][2], m_cent[1][1], m_cent[1][0],
                m_cent[0][3], m_cent[0][2], m_cent[0][1], m_cent[0][0]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            for (int j = 0; j < 4; j++) m_sum[k][j] = 0;
        end
    endtask

    task automatic load(input logic idx, input logic [W-1:0] a, b, c, d);
        load_idx = idx; load_d0 = a; load_d1 = b; load_d2 = c; load_d3 = d;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        m_cent[idx][0] = a; m_cent[idx][1] = b; m_cent[idx][2] = c; m_cent[idx][3] = d;
    endtask

    task automatic send(input logic idx, input logic [W-1:0] a, b, c, d, input logic last);
        in_idx = idx; in_data0 = a; in_data1 = b; in_data2 = c; in_data3 = d;
        in_last = last; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        m_sum[idx][0] += a; m_sum[idx][1] += b; m_sum[idx][2] += c; m_sum[idx][3] += d;
        m_cnt[idx]++;
        if (last) begin
            for (int k = 0; k < 2; k++)
                if (m_cnt[k] != 0)
                    for (int j = 0; j < 4; j++) m_cent[k][j] = W'(m_sum[k][j] / m_cnt[k]);
            exp_q.push_back(model_pack());
            model_clear();
        end
    endtask

    task automatic send_b(input logic [W-1:0] a, b, c, d, input logic last);
        in_idx = 1'b0; in_data0 = a; in_data1 = b; in_data2 = c; in_data3 = d;
        in_last_b = last; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0; in_last_b = 1'b0;
    endtask

    // Called right after the in_last edge; optionally pokes inputs mid-divide.
    task automatic run_divide(input string tag, input int pulse_at, input int exp_lat);
        int   cyc;
        logic busy_ok;
        logic [127:0] exp;
        cyc = 0;
        busy_ok = 1'b1;
        while (!update_done && cyc < 400) begin
            if (cyc == pulse_at) begin
                in_idx = 1'b0; in_data0 = 50; in_data1 = 50; in_data2 = 50; in_data3 = 50;
                in_valid = 1'b1;
                load_idx = 1'b1; load_d0 = 7; load_d1 = 7; load_d2 = 7; load_d3 = 7;
                load_en = 1'b1;
            end else begin
                in_valid = 1'b0;
                load_en = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        load_en = 1'b0;
        chk({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
        chk({tag, "_busy_held"}, 128'(busy_ok), 128'(1));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_centroids"}, obs_a(), exp);
        end
        chk({tag, "_cleared"}, 128'({count0, count1, busy}), 128'(0));
        tick();
        chk({tag, "_done_pulse"}, 128'(update_done), 128'(0));
    endtask

    initial begin
        int cyc;
        int seen;
        logic [127:0] exp;
        rst = 1'b1;
        in_valid = 1'b0; in_valid_b = 1'b0; in_last = 1'b0; in_last_b = 1'b0; in_idx = 1'b0;
        in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
        load_en = 1'b0; load_idx = 1'b0;
        load_d0 = '0; load_d1 = '0; load_d2 = '0; load_d3 = '0;
        model_clear();
        for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) m_cent[k][j] = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_centroids", obs_a(), 128'(0));
        chk("reset_flags", 128'({count0, count1, busy, update_done, err_drop, err_ovf, dbg_state}), 128'(0));

        // Mean of two points to centroid 0; centroid 1 is empty and keeps its load value.
        load(1'b0, 0, 0, 0, 0);
        load(1'b1, 100, 100, 100, 100);
        send(1'b0, 2, 4, 6, 8, 1'b0);
        send(1'b0, 10, 10, 10, 10, 1'b1);
        chk("s1_counts_held", 128'({count0, count1}), 128'({16'd2, 16'd0}));
        chk("s1_busy_state", 128'({busy, dbg_state}), 128'(2'b11));
        run_divide("s1", -1, 265);

        // Floor of a non-integer mean.
        send(1'b1, 1, 1, 1, 1, 1'b0);
        send(1'b1, 2, 2, 2, 2, 1'b1);
        run_divide("s2", -1, 265);

        // Inputs during DIVIDE are dropped and flagged.
        load(1'b0, 0, 0, 0, 0);
        load(1'b1, 100, 100, 100, 100);
        chk("s4_drop_before", 128'(err_drop), 128'(0));
        send(1'b0, 2, 4, 6, 8, 1'b0);
        send(1'b0, 10, 10, 10, 10, 1'b1);
        run_divide("s4", 20, 265);
        chk("s4_drop_after", 128'({err_drop, err_ovf}), 128'(2'b10));

        // Saturating 2-bit counter: the 4th point is counted out and excluded from the sum.
        send_b(1, 2, 3, 4, 1'b0);
        send_b(5, 5, 5, 5, 1'b0);
        send_b(7, 7, 7, 7, 1'b0);
        chk("s5_count3", 128'({count0_b, err_ovf_b}), 128'({2'd3, 1'b0}));
        exp_q.push_back({64'd0, 16'd5, 16'd5, 16'd4, 16'd4});
        send_b(100, 100, 100, 100, 1'b1);
        chk("s5_saturated", 128'({count0_b, err_ovf_b, busy_b}), 128'({2'd3, 1'b1, 1'b1}));
        cyc = 0;
        while (!update_done_b && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("s5_latency", 128'(cyc), 128'(1 + 8 * 19));
        exp = exp_q.pop_front();
        chk("s5_centroids", obs_b(), exp);

        // Reset in the middle of a divide aborts everything.
        send(1'b0, 5, 5, 5, 5, 1'b1);
        exp_q.delete();
        repeat (10) tick();
        chk("s6_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("s6_centroids", obs_a(), 128'(0));
        chk("s6_flags", 128'({count0, count1, busy, update_done, err_drop, err_ovf, dbg_state}), 128'(0));
        seen = 0;
        repeat (300) begin
            tick();
            if (update_done) seen++;
        end
        chk("s6_no_done", 128'(seen), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
